// File: rtl/switch_receiver_db.sv
// Switch / user-key input receiver.
// Synchronises and debounces up to eight 8-bit switch groups plus one
// active-low user-key group. Debounced values, latched change events (W1C)
// and an interrupt mask/enable are exposed through a small register window.
module switch_receiver_db #(
  parameter int SW_GROUPS = 8,      // populated 8-bit switch groups (1..8)
  parameter int KEY_WIDTH = 8,      // user-key bus width (1..8)
  parameter int DB_CYCLES = 50000   // stable cycles needed to accept a value (>=2)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [8*SW_GROUPS-1:0] switch,
  input  logic [KEY_WIDTH-1:0]   userkey,
  input  logic [7:0]             Address,
  input  logic                   We,
  input  logic [31:0]            DataIn,
  output logic [31:0]            DataOut,
  output logic                   irq
);

  localparam int NG = 9;            // groups 0..7 switches, group 8 keys
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES);

  localparam logic [7:0] ADDR_SW_LO  = 8'h2C;
  localparam logic [7:0] ADDR_SW_HI  = 8'h30;
  localparam logic [7:0] ADDR_KEY    = 8'h34;
  localparam logic [7:0] ADDR_STATUS = 8'h38;
  localparam logic [7:0] ADDR_CTRL   = 8'h3C;

  logic [8*SW_GROUPS-1:0] sw_s1, sw_s2;
  logic [KEY_WIDTH-1:0]   key_s1, key_s2;
  logic [NG-1:0][7:0]     sync_val;
  logic [NG-1:0][7:0]     stable;
  logic [NG-1:0]          set_ev;
  logic [NG-1:0]          pending, mask, clr;
  logic                   ie;
  logic                   irq_r;

  // Two-flop synchronisers for every raw pin.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      key_s1 <= '0;
      key_s2 <= '0;
    end else begin
      // NOTE: non-blocking assignments make s2 take the old s1, forming a real two-stage chain.
      sw_s1  <= switch;
      sw_s2  <= sw_s1;
      key_s1 <= userkey;
      key_s2 <= key_s1;
    end
  end

  // Per-group synchronised values; keys inverted so a pressed key reads 1.
  always_comb begin
    // NOTE: a full default before the loops keeps every bit assigned on every pass, so no latch is inferred.
    sync_val = '0;
    for (int g = 0; g < SW_GROUPS; g++) sync_val[g] = sw_s2[8*g +: 8];
    sync_val[NG-1][KEY_WIDTH-1:0] = ~key_s2;
  end

  for (genvar g = 0; g < NG; g++) begin : g_grp
    if (g < SW_GROUPS || g == NG-1) begin : g_on
      logic [7:0]    cand;
      logic [CW-1:0] cnt;
      logic [7:0]    stable_r;
      logic          primed;
      logic          accept;

      // The counter becomes DB_CYCLES on this edge (or already sits there).
      assign accept    = (sync_val[g] == cand) && (cnt >= CNT_MAX - 1'b1);
      assign set_ev[g] = accept && primed && (cand != stable_r);
      assign stable[g] = stable_r;

      // Debounce: restart on any difference, otherwise count up and accept.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cand     <= '0;
          cnt      <= '0;
          stable_r <= '0;
          primed   <= 1'b0;
        end else if (sync_val[g] != cand) begin
          cand <= sync_val[g];
          cnt  <= '0;
        end else begin
          if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
          // First acceptance after reset primes the group silently.
          if (accept && (!primed || cand != stable_r)) begin
            stable_r <= cand;
            primed   <= 1'b1;
          end
        end
      end
    end else begin : g_off
      assign set_ev[g] = 1'b0;
      assign stable[g] = '0;
    end
  end

  assign clr = (We && Address == ADDR_STATUS) ? DataIn[8:0] : '0;

  // Status, control and the registered interrupt; a new event beats a W1C.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending <= '0;
      mask    <= '0;
      ie      <= 1'b0;
      irq_r   <= 1'b0;
    end else begin
      pending <= (pending & ~clr) | set_ev;
      if (We && Address == ADDR_CTRL) begin
        mask <= DataIn[8:0];
        ie   <= DataIn[31];
      end
      irq_r <= ie & |(pending & mask);
    end
  end

  assign irq = irq_r;

  // Combinational read decode.
  always_comb begin
    DataOut = '0;
    case (Address)
      ADDR_SW_LO:  DataOut = {stable[3], stable[2], stable[1], stable[0]};
      ADDR_SW_HI:  DataOut = {stable[7], stable[6], stable[5], stable[4]};
      ADDR_KEY:    DataOut = {24'b0, stable[8]};
      ADDR_STATUS: DataOut = {23'b0, pending};
      ADDR_CTRL:   DataOut = {ie, 22'b0, mask};
      default:     DataOut = '0;
    endcase
  end

  // Write-data bits with no destination register.
  logic unused_bits;
  assign unused_bits = ^{DataIn[30:9], sync_val};

endmodule

// File: tb/tb_switch_receiver_db.sv
// Bench for switch_receiver_db: two instances (8 groups/8 keys and
// 3 groups/4 keys, both DB_CYCLES=4) share stimulus. A run-length model
// predicts every register and irq each cycle; literal checks pin key points.
module tb_switch_receiver_db;

  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] switch;
  logic [7:0]  userkey;
  logic [7:0]  Address;
  logic        We;
  logic [31:0] DataIn;
  logic [31:0] dout_a, dout_b;
  logic        irq_a, irq_b;

  int errors = 0;
  int checks = 0;
  bit check_on = 1'b0;

  always #5 clk = ~clk;

  switch_receiver_db #(.SW_GROUPS(8), .KEY_WIDTH(8), .DB_CYCLES(DB)) dut_a (
    .clk(clk), .rst_n(rst_n), .switch(switch), .userkey(userkey),
    .Address(Address), .We(We), .DataIn(DataIn), .DataOut(dout_a), .irq(irq_a)
  );

  switch_receiver_db #(.SW_GROUPS(3), .KEY_WIDTH(4), .DB_CYCLES(DB)) dut_b (
    .clk(clk), .rst_n(rst_n), .switch(switch[23:0]), .userkey(userkey[3:0]),
    .Address(Address), .We(We), .DataIn(DataIn), .DataOut(dout_b), .irq(irq_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A group accepts value v once v has been seen on DB+1 consecutive
  // sampled edges (the reset itself counts as one sample of 0).
  logic [7:0] m_stable [2][9];
  logic       m_primed [2][9];
  logic [7:0] m_last   [2][9];
  int         m_run    [2][9];
  logic [7:0] m_p1     [2][9];   // pin value one edge ago
  logic [7:0] m_p2     [2][9];   // pin value two edges ago
  logic [8:0] m_pending [2];
  logic [8:0] m_mask    [2];
  logic       m_ie      [2];
  logic       m_irq     [2];

  function automatic int n_groups(input int i);
    return (i == 0) ? 8 : 3;
  endfunction

  function automatic logic [7:0] key_mask(input int i);
    return (i == 0) ? 8'hFF : 8'h0F;
  endfunction

  function automatic logic [7:0] pin_of(input int i, input int g);
    if (g == 8) return userkey & key_mask(i);
    if (g < n_groups(i)) return switch[8*g +: 8];
    return 8'h00;
  endfunction

  function automatic logic [31:0] m_read(input int i, input logic [7:0] a);
    case (a)
      8'h2C:   return {m_stable[i][3], m_stable[i][2], m_stable[i][1], m_stable[i][0]};
      8'h30:   return {m_stable[i][7], m_stable[i][6], m_stable[i][5], m_stable[i][4]};
      8'h34:   return {24'b0, m_stable[i][8]};
      8'h38:   return {23'b0, m_pending[i]};
      8'h3C:   return {m_ie[i], 22'b0, m_mask[i]};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin : model
    logic [8:0] set_v;
    logic [8:0] clr_v;
    logic [7:0] seen;
    logic       nirq;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        for (int g = 0; g < 9; g++) begin
          m_stable[i][g] = 8'h00;
          m_primed[i][g] = 1'b0;
          m_last[i][g]   = 8'h00;
          m_run[i][g]    = 1;
          m_p1[i][g]     = 8'h00;
          m_p2[i][g]     = 8'h00;
        end
        m_pending[i] = '0;
        m_mask[i]    = '0;
        m_ie[i]      = 1'b0;
        m_irq[i]     = 1'b0;
      end else begin
        nirq  = m_ie[i] & |(m_pending[i] & m_mask[i]);
        set_v = '0;
        for (int g = 0; g < 9; g++) begin
          seen = (g == 8) ? (~m_p2[i][g] & key_mask(i)) : m_p2[i][g];
          if (seen == m_last[i][g]) begin
            if (m_run[i][g] < 1000) m_run[i][g] = m_run[i][g] + 1;
          end else begin
            m_last[i][g] = seen;
            m_run[i][g]  = 1;
          end
          if (m_run[i][g] >= DB + 1) begin
            if (!m_primed[i][g]) begin
              m_stable[i][g] = m_last[i][g];
              m_primed[i][g] = 1'b1;
            end else if (m_stable[i][g] != m_last[i][g]) begin
              m_stable[i][g] = m_last[i][g];
              set_v[g] = 1'b1;
            end
          end
          m_p2[i][g] = m_p1[i][g];
          m_p1[i][g] = pin_of(i, g);
        end
        clr_v = (We && Address == 8'h38) ? DataIn[8:0] : 9'h0;
        m_pending[i] = (m_pending[i] & ~clr_v) | set_v;
        if (We && Address == 8'h3C) begin
          m_mask[i] = DataIn[8:0];
          m_ie[i]   = DataIn[31];
        end
        m_irq[i] = nirq;
      end
    end
  end

  // Per-cycle compare of both instances against the model.
  always begin
    @(posedge clk);
    #2;
    if (check_on) begin
      check("model_dout_a", dout_a, m_read(0, Address));
      check("model_irq_a", {31'b0, irq_a}, {31'b0, m_irq[0]});
      check("model_dout_b", dout_b, m_read(1, Address));
      check("model_irq_b", {31'b0, irq_b}, {31'b0, m_irq[1]});
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0] rot_addr [7] = '{8'h2C, 8'h30, 8'h34, 8'h38, 8'h3C, 8'h40, 8'h00};
  int rot_idx = 0;

  task automatic step();
    @(negedge clk);
    We      = 1'b0;
    DataIn  = 32'h0;
    Address = rot_addr[rot_idx];
    rot_idx = (rot_idx + 1) % 7;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    Address = a;
    We      = 1'b1;
    DataIn  = d;
  endtask

  task automatic rd(input int which, input logic [7:0] a, input logic [31:0] exp, input string name);
    Address = a;
    #1;
    check(name, (which == 0) ? dout_a : dout_b, exp);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : stim
    rst_n   = 1'b0;
    We      = 1'b0;
    Address = 8'h00;
    DataIn  = 32'h0;
    switch  = 64'h0102_0304_0506_0708;
    userkey = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    check_on = 1'b1;

    // Reset state
    step(); step();
    rd(0, 8'h2C, 32'h0, "reset_sw_lo");
    rd(0, 8'h3C, 32'h0, "reset_ctrl");
    check("reset_irq", {31'b0, irq_a}, 32'h0);

    // Priming: values appear after 7 edges, no pending
    step(); rst_n = 1'b1;
    repeat (6) step();
    rd(0, 8'h2C, 32'h0, "prime_not_yet");
    step();
    rd(0, 8'h2C, 32'h0506_0708, "prime_sw_lo");
    rd(0, 8'h30, 32'h0102_0304, "prime_sw_hi");
    rd(0, 8'h38, 32'h0, "prime_status");
    rd(1, 8'h2C, 32'h0006_0708, "b_sw_lo_absent");
    rd(1, 8'h30, 32'h0, "b_sw_hi_absent");
    check("prime_irq", {31'b0, irq_a}, 32'h0);
    repeat (5) step();

    // g0 change: exactly 7 edges of latency, pending bit0
    step(); switch[7:0] = 8'hFF;
    repeat (6) step();
    rd(0, 8'h2C, 32'h0506_0708, "g0_at_6");
    step();
    rd(0, 8'h2C, 32'h0506_07FF, "g0_at_7");
    rd(0, 8'h38, 32'h0000_0001, "g0_status");
    rd(1, 8'h38, 32'h0000_0001, "b_g0_status");

    // Enable irq for bit0: irq follows one cycle after the CTRL write
    wr(8'h3C, 32'h8000_0001);
    step();
    check("irq_lag", {31'b0, irq_a}, 32'h0);
    rd(0, 8'h3C, 32'h8000_0001, "ctrl_read");
    step();
    check("irq_on", {31'b0, irq_a}, 32'h1);

    // 3-cycle glitch on g2 is rejected
    step(); switch[23:16] = 8'hAA;
    repeat (2) step();
    step(); switch[23:16] = 8'h06;
    repeat (10) step();
    rd(0, 8'h2C, 32'h0506_07FF, "glitch_sw_lo");
    rd(0, 8'h38, 32'h0000_0001, "glitch_status");

    // Sustained change on g2 is accepted
    step(); switch[23:16] = 8'hAA;
    repeat (7) step();
    rd(0, 8'h2C, 32'h05AA_07FF, "hold_sw_lo");
    rd(0, 8'h38, 32'h0000_0005, "hold_status");

    // Key press with only the key group unmasked
    wr(8'h3C, 32'h8000_0100);
    step(); step();
    check("key_mask_irq", {31'b0, irq_a}, 32'h0);
    step(); userkey[0] = 1'b0;
    repeat (7) step();
    rd(0, 8'h34, 32'h0000_0001, "key_read");
    rd(0, 8'h38, 32'h0000_0105, "key_status");
    rd(1, 8'h34, 32'h0000_0001, "b_key_read");
    check("key_irq_lag", {31'b0, irq_a}, 32'h0);
    step();
    check("key_irq_on", {31'b0, irq_a}, 32'h1);

    // W1C of bit8: bit clears, irq drops a cycle later
    wr(8'h38, 32'h0000_0100);
    step();
    rd(0, 8'h38, 32'h0000_0005, "w1c_status");
    check("w1c_irq_lag", {31'b0, irq_a}, 32'h1);
    step();
    check("w1c_irq_off", {31'b0, irq_a}, 32'h0);

    // Clear of bit0 on the same edge as a new g0 event: set wins
    step(); switch[7:0] = 8'h11;
    repeat (5) step();
    wr(8'h38, 32'h0000_0001);
    step();
    rd(0, 8'h38, 32'h0000_0005, "set_wins_status");
    rd(0, 8'h2C, 32'h05AA_0711, "set_wins_sw_lo");

    // Plain clear, then a long quiet period with saturated counters
    wr(8'h38, 32'h0000_0005);
    step();
    rd(0, 8'h38, 32'h0, "clear_status");
    repeat (40) step();
    rd(0, 8'h38, 32'h0, "long_hold_status");

    // Reset in the middle of a g1 debounce
    step(); switch[15:8] = 8'h33;
    repeat (3) step();
    rst_n = 1'b0;
    step(); step();
    rd(0, 8'h2C, 32'h0, "mid_rst_sw_lo");
    rd(0, 8'h34, 32'h0, "mid_rst_key");
    rd(0, 8'h3C, 32'h0, "mid_rst_ctrl");
    check("mid_rst_irq", {31'b0, irq_a}, 32'h0);
    step(); rst_n = 1'b1;
    repeat (7) step();
    rd(0, 8'h2C, 32'h05AA_3311, "reprime_sw_lo");
    rd(0, 8'h34, 32'h0000_0001, "reprime_key");
    rd(0, 8'h38, 32'h0, "reprime_status");
    rd(1, 8'h2C, 32'h00AA_3311, "b_reprime_sw_lo");
    rd(0, 8'h40, 32'h0, "unmapped_read");
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
